// File: rtl/instr_fetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
//   DATA_W       : width of instruction words and PCs
//   DATA_BUS     : one instruction word or PC
//   NOP_INSTR    : bubble instruction (addi x0,x0,0) shown when the queue is empty
//   FETCH_ENTRY  : one buffered {instr, pc} pair
//   BUBBLE_ENTRY : reset/empty value of an entry
package instr_fetch_queue_pkg;

    localparam int DATA_W = 32;

    typedef logic [DATA_W-1:0] DATA_BUS;

    localparam DATA_BUS NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        DATA_BUS instr;
        DATA_BUS pc;
    } FETCH_ENTRY;

    localparam FETCH_ENTRY BUBBLE_ENTRY = {NOP_INSTR, 32'h0000_0000};

endpackage

// File: rtl/fetch_queue_mem.sv
// Register file holding the buffered fetch entries.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset, clears every entry to BUBBLE_ENTRY
//   we    : write enable
//   waddr : write index
//   wdata : entry to write
//   raddr : read index
//   rdata : entry at raddr (asynchronous read)
module fetch_queue_mem
    import instr_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  FETCH_ENTRY    wdata,
    input  logic [AW-1:0] raddr,
    output FETCH_ENTRY    rdata
);

    FETCH_ENTRY mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= BUBBLE_ENTRY;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // DEPTH is a power of two, so every raddr value addresses a real entry.
    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction prefetch queue between fetch and decode. Buffers {instr, pc}
// pairs so fetch keeps running while decode stalls; flush drops everything
// on a branch/jump redirect.
//   clk, rst      : clock, asynchronous active-high reset
//   flush         : discard all entries (synchronous, beats push and pop)
//   in_valid/in_ready, in_instr, in_pc : fetch-side handshake and data
//   out_valid/out_ready, out_instr, out_pc, out_pc_plus4 : decode-side
//                   handshake and head entry (first-word-fall-through)
//   count         : occupancy, 0..DEPTH
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready depends only on registered occupancy (no path from
// out_ready), so a full queue refuses a push even while it pops.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_instr,
    input  logic [DATA_W-1:0]        in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_instr,
    output logic [DATA_W-1:0]        out_pc,
    output logic [DATA_W-1:0]        out_pc_plus4,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    FETCH_ENTRY    head;

    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({in_instr, in_pc}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage keeps stale words after a flush, so the bubble is forced
    // explicitly whenever the queue is empty.
    assign out_instr    = out_valid ? head.instr : NOP_INSTR;
    assign out_pc       = out_valid ? head.pc    : '0;
    assign out_pc_plus4 = out_pc + 32'd4;

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic [2:0]  count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_q[$];

    typedef struct {
        logic        flush;
        logic        in_valid;
        logic [31:0] in_instr;
        logic [31:0] in_pc;
        logic        out_ready;
        logic        exp_valid;
        logic        exp_ready;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
        logic [31:0] exp_pc4;
        logic [2:0]  exp_count;
    } vec_t;

    vec_t vq[$];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    instr_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_pc_plus4 (out_pc_plus4),
        .count        (count)
    );

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Outputs expected in the cycle before an edge, plus the inputs applied at that edge.
    task automatic add(input logic fl, input logic iv, input logic [31:0] ii, input logic [31:0] ip,
                       input logic ordy, input logic ev, input logic er, input logic [31:0] ei,
                       input logic [31:0] ep, input logic [31:0] ep4, input logic [2:0] ec);
        vec_t v;
        v.flush = fl; v.in_valid = iv; v.in_instr = ii; v.in_pc = ip; v.out_ready = ordy;
        v.exp_valid = ev; v.exp_ready = er; v.exp_instr = ei; v.exp_pc = ep;
        v.exp_pc4 = ep4; v.exp_count = ec;
        vq.push_back(v);
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [31:0] ii,
                         input logic [31:0] ip, input logic ordy);
        flush = fl; in_valid = iv; in_instr = ii; in_pc = ip; out_ready = ordy;
    endtask

    task automatic check_bubble(input string tag);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_in_ready"},  {31'd0, in_ready},  32'd1);
        check({tag, "_count"},     {29'd0, count},     32'd0);
        check({tag, "_out_instr"}, out_instr,          NOP);
        check({tag, "_out_pc"},    out_pc,             32'd0);
    endtask

    initial begin
        // ---------------- reset ----------------
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        #2;
        check_bubble("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- directed vector table ----------------
        //   fl iv instr          pc             ordy | ov er instr          pc             pc4            cnt
        // fill 0xA0..0xA3, fifth push refused while full
        add(0, 1, 32'hA0,       32'd0,         0,     0, 1, NOP,           32'd0,         32'd4,         3'd0);
        add(0, 1, 32'hA1,       32'd4,         0,     1, 1, 32'hA0,        32'd0,         32'd4,         3'd1);
        add(0, 1, 32'hA2,       32'd8,         0,     1, 1, 32'hA0,        32'd0,         32'd4,         3'd2);
        add(0, 1, 32'hA3,       32'd12,        0,     1, 1, 32'hA0,        32'd0,         32'd4,         3'd3);
        add(0, 1, 32'hA4,       32'd16,        0,     1, 0, 32'hA0,        32'd0,         32'd4,         3'd4);
        // drain in order
        add(0, 0, 32'd0,        32'd0,         1,     1, 0, 32'hA0,        32'd0,         32'd4,         3'd4);
        add(0, 0, 32'd0,        32'd0,         1,     1, 1, 32'hA1,        32'd4,         32'd8,         3'd3);
        add(0, 0, 32'd0,        32'd0,         1,     1, 1, 32'hA2,        32'd8,         32'd12,        3'd2);
        add(0, 0, 32'd0,        32'd0,         1,     1, 1, 32'hA3,        32'd12,        32'd16,        3'd1);
        add(0, 0, 32'd0,        32'd0,         1,     0, 1, NOP,           32'd0,         32'd4,         3'd0);
        // full with pop: push refused, head advances by one
        add(0, 1, 32'hB0,       32'h100,       0,     0, 1, NOP,           32'd0,         32'd4,         3'd0);
        add(0, 1, 32'hB1,       32'h104,       0,     1, 1, 32'hB0,        32'h100,       32'h104,       3'd1);
        add(0, 1, 32'hB2,       32'h108,       0,     1, 1, 32'hB0,        32'h100,       32'h104,       3'd2);
        add(0, 1, 32'hB3,       32'h10C,       0,     1, 1, 32'hB0,        32'h100,       32'h104,       3'd3);
        add(0, 1, 32'hB4,       32'h110,       1,     1, 0, 32'hB0,        32'h100,       32'h104,       3'd4);
        add(0, 0, 32'd0,        32'd0,         0,     1, 1, 32'hB1,        32'h104,       32'h108,       3'd3);
        // pop once to reach count=2, then flush with push and pop pending
        add(0, 0, 32'd0,        32'd0,         1,     1, 1, 32'hB1,        32'h104,       32'h108,       3'd3);
        add(1, 1, 32'hC0,       32'h200,       1,     1, 1, 32'hB2,        32'h108,       32'h10C,       3'd2);
        add(0, 0, 32'd0,        32'd0,         0,     0, 1, NOP,           32'd0,         32'd4,         3'd0);
        // pc + 4 wraps
        add(0, 1, 32'hDEAD,     32'hFFFF_FFFC, 0,     0, 1, NOP,           32'd0,         32'd4,         3'd0);
        add(0, 0, 32'd0,        32'd0,         0,     1, 1, 32'hDEAD,      32'hFFFF_FFFC, 32'h0,         3'd1);
        add(0, 0, 32'd0,        32'd0,         1,     1, 1, 32'hDEAD,      32'hFFFF_FFFC, 32'h0,         3'd1);
        add(0, 0, 32'd0,        32'd0,         0,     0, 1, NOP,           32'd0,         32'd4,         3'd0);

        foreach (vq[i]) begin
            drive(vq[i].flush, vq[i].in_valid, vq[i].in_instr, vq[i].in_pc, vq[i].out_ready);
            #1;
            check($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vq[i].exp_valid});
            check($sformatf("v%0d_in_ready", i),  {31'd0, in_ready},  {31'd0, vq[i].exp_ready});
            check($sformatf("v%0d_out_instr", i), out_instr,          vq[i].exp_instr);
            check($sformatf("v%0d_out_pc", i),    out_pc,             vq[i].exp_pc);
            check($sformatf("v%0d_pc_plus4", i),  out_pc_plus4,       vq[i].exp_pc4);
            check($sformatf("v%0d_count", i),     {29'd0, count},     {29'd0, vq[i].exp_count});
            @(negedge clk);
        end

        // ---------------- streaming: push and pop every cycle ----------------
        exp_q.delete();
        for (int i = 0; i < 11; i++) begin
            if (i < 10) drive(1'b0, 1'b1, 32'h50 + i, 32'(4 * i), 1'b1);
            else        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
            #1;
            check($sformatf("s%0d_count", i), {29'd0, count}, 32'(exp_q.size()));
            check($sformatf("s%0d_out_valid", i), {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
            if (exp_q.size() != 0) check($sformatf("s%0d_out_instr", i), out_instr, exp_q[0]);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            if (in_valid && exp_q.size() < DEPTH) exp_q.push_back(in_instr);
            @(negedge clk);
        end
        check("s_end_count", {29'd0, count}, 32'd0);

        // ---------------- asynchronous reset mid-stream ----------------
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 32'hD0 + i, 32'(8 * i), 1'b0);
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        #1;
        check("pre_rst_count", {29'd0, count}, 32'd3);
        check("pre_rst_head", out_instr, 32'hD0);
        rst = 1'b1;
        #1;
        check_bubble("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_bubble("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
